// File: rtl/mem_chk_pkg.sv
// Shared types and helpers for the memory write checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_DATA    = 2'd1;
    localparam logic [1:0] FC_ADDR    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mem_chk_match.sv
// Priority address matcher: lowest valid slot whose address equals the store address.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mem_chk_match #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 8,
    parameter int IDX_W      = 3
) (
    input  logic [NUM_CHECKS-1:0]        slot_vld,
    input  logic [NUM_CHECKS*ADDR_W-1:0] slot_addr_dat,
    input  logic [NUM_CHECKS*DATA_W-1:0] slot_data_dat,
    input  logic [NUM_CHECKS*DATA_W-1:0] slot_mask_dat,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    output logic                         hit_vld,
    output logic [IDX_W-1:0]             hit_idx,
    output logic                         data_ok
);

    // Walk from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit_vld = 1'b0;
        hit_idx = '0;
        data_ok = 1'b0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (slot_vld[i] && (slot_addr_dat[i*ADDR_W +: ADDR_W] == st_addr)) begin
                hit_vld = 1'b1;
                hit_idx = IDX_W'(i);
                data_ok = (((st_data ^ slot_data_dat[i*DATA_W +: DATA_W])
                            & slot_mask_dat[i*DATA_W +: DATA_W]) == '0);
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Store monitor: checks core writes against a table of expected (addr, data, mask) entries.
// Latency: a store sampled on an edge is reflected in status/error outputs right after it.
// Backpressure: none; observes the write port passively and never stalls the core.
module mem_write_checker
    import mem_chk_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CHECKS     = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ORDERED        = 0,
    parameter int STRICT         = 1,
    localparam int IDX_W         = idx_width(NUM_CHECKS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [IDX_W-1:0]  err_idx,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic [IDX_W:0]    hit_count,
    output logic [31:0]       cycle_count
);

    localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

    chk_state_e                  state_q, state_d;
    logic [NUM_CHECKS-1:0]        slot_vld_q, slot_vld_d;
    logic [NUM_CHECKS*ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [NUM_CHECKS*DATA_W-1:0] slot_data_q, slot_data_d;
    logic [NUM_CHECKS*DATA_W-1:0] slot_mask_q, slot_mask_d;
    logic [NUM_CHECKS-1:0]        hit_q, hit_d;
    logic [IDX_W:0]               seq_ptr_q, seq_ptr_d;
    logic [1:0]                   fail_code_q, fail_code_d;
    logic [IDX_W-1:0]             err_idx_q, err_idx_d;
    logic [ADDR_W-1:0]            err_addr_q, err_addr_d;
    logic [DATA_W-1:0]            err_data_q, err_data_d;
    logic [IDX_W:0]               hit_count_q, hit_count_d;
    logic [31:0]                  cycle_count_q, cycle_count_d;

    logic             m_hit_vld;
    logic [IDX_W-1:0] m_hit_idx;
    logic             m_data_ok;

    logic             ord_vld;
    logic [IDX_W-1:0] ord_idx;
    logic             ord_addr_ok;
    logic             ord_data_ok;
    logic [IDX_W:0]   num_valid;

    logic             st_fail;
    logic [1:0]       st_code;
    logic [IDX_W-1:0] st_idx;

    mem_chk_match #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_CHECKS (NUM_CHECKS),
        .IDX_W      (IDX_W)
    ) u_match (
        .slot_vld      (slot_vld_q),
        .slot_addr_dat (slot_addr_q),
        .slot_data_dat (slot_data_q),
        .slot_mask_dat (slot_mask_q),
        .st_addr       (data_adr),
        .st_data       (write_data),
        .hit_vld       (m_hit_vld),
        .hit_idx       (m_hit_idx),
        .data_ok       (m_data_ok)
    );

    // Ordered mode targets the first valid slot at or beyond seq_ptr, skipping holes.
    always_comb begin
        ord_vld   = 1'b0;
        ord_idx   = '0;
        num_valid = '0;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            num_valid = num_valid + (IDX_W+1)'(slot_vld_q[i]);
            if (slot_vld_q[i] && (i >= int'(seq_ptr_q))) begin
                ord_vld = 1'b1;
                ord_idx = IDX_W'(i);
            end
        end
        ord_addr_ok = (slot_addr_q[ord_idx*ADDR_W +: ADDR_W] == data_adr);
        ord_data_ok = (((write_data ^ slot_data_q[ord_idx*DATA_W +: DATA_W])
                        & slot_mask_q[ord_idx*DATA_W +: DATA_W]) == '0);
    end

    always_comb begin
        state_d       = state_q;
        slot_vld_d    = slot_vld_q;
        slot_addr_d   = slot_addr_q;
        slot_data_d   = slot_data_q;
        slot_mask_d   = slot_mask_q;
        hit_d         = hit_q;
        seq_ptr_d     = seq_ptr_q;
        fail_code_d   = fail_code_q;
        err_idx_d     = err_idx_q;
        err_addr_d    = err_addr_q;
        err_data_d    = err_data_q;
        hit_count_d   = hit_count_q;
        cycle_count_d = cycle_count_q;
        st_fail       = 1'b0;
        st_code       = FC_NONE;
        st_idx        = '0;

        case (state_q)
            RUN: begin
                if (mem_write) begin
                    if (ORDERED == 0) begin
                        if (m_hit_vld) begin
                            if (m_data_ok) begin
                                hit_d[m_hit_idx] = 1'b1;
                                if (!hit_q[m_hit_idx]) hit_count_d = hit_count_q + CNT_ONE;
                            end else begin
                                st_fail = 1'b1;
                                st_code = FC_DATA;
                                st_idx  = m_hit_idx;
                            end
                        end else if (STRICT != 0) begin
                            st_fail = 1'b1;
                            st_code = FC_ADDR;
                        end
                    end else begin
                        if (!ord_vld || !ord_addr_ok) begin
                            st_fail = 1'b1;
                            st_code = FC_ADDR;
                            st_idx  = ord_idx;
                        end else if (!ord_data_ok) begin
                            st_fail = 1'b1;
                            st_code = FC_DATA;
                            st_idx  = ord_idx;
                        end else begin
                            hit_d[ord_idx] = 1'b1;
                            hit_count_d    = hit_count_q + CNT_ONE;
                            seq_ptr_d      = {1'b0, ord_idx} + CNT_ONE;
                        end
                    end
                end

                // Store outcome outranks the timeout evaluated on the same edge.
                if (st_fail) begin
                    state_d     = FAIL;
                    fail_code_d = st_code;
                    err_idx_d   = st_idx;
                    err_addr_d  = data_adr;
                    err_data_d  = write_data;
                end else if (hit_count_d == num_valid) begin
                    state_d = PASS;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (cycle_count_q == 32'(TIMEOUT_CYCLES - 1))) begin
                    state_d     = FAIL;
                    fail_code_d = FC_TIMEOUT;
                    err_idx_d   = '0;
                    err_addr_d  = '0;
                    err_data_d  = '0;
                end else if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end

                if (clear) state_d = IDLE;
            end

            default: begin
                if (cfg_we && (int'(cfg_idx) < NUM_CHECKS)) begin
                    slot_vld_d[cfg_idx]                    = cfg_valid;
                    slot_addr_d[cfg_idx*ADDR_W +: ADDR_W] = cfg_addr;
                    slot_data_d[cfg_idx*DATA_W +: DATA_W] = cfg_data;
                    slot_mask_d[cfg_idx*DATA_W +: DATA_W] = cfg_mask;
                end
                if (clear) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d       = RUN;
                    hit_d         = '0;
                    hit_count_d   = '0;
                    cycle_count_d = '0;
                    seq_ptr_d     = '0;
                    fail_code_d   = FC_NONE;
                    err_idx_d     = '0;
                    err_addr_d    = '0;
                    err_data_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            slot_vld_q    <= '0;
            slot_addr_q   <= '0;
            slot_data_q   <= '0;
            slot_mask_q   <= '0;
            hit_q         <= '0;
            seq_ptr_q     <= '0;
            fail_code_q   <= FC_NONE;
            err_idx_q     <= '0;
            err_addr_q    <= '0;
            err_data_q    <= '0;
            hit_count_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            slot_vld_q    <= slot_vld_d;
            slot_addr_q   <= slot_addr_d;
            slot_data_q   <= slot_data_d;
            slot_mask_q   <= slot_mask_d;
            hit_q         <= hit_d;
            seq_ptr_q     <= seq_ptr_d;
            fail_code_q   <= fail_code_d;
            err_idx_q     <= err_idx_d;
            err_addr_q    <= err_addr_d;
            err_data_q    <= err_data_d;
            hit_count_q   <= hit_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == PASS) || (state_q == FAIL);
    assign pass        = (state_q == PASS);
    assign fail_code   = fail_code_q;
    assign err_idx     = err_idx_q;
    assign err_addr    = err_addr_q;
    assign err_data    = err_data_q;
    assign hit_count   = hit_count_q;
    assign cycle_count = cycle_count_q;

endmodule
